// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble.
module if_id_register
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        write_en,
    input  logic        load,
    input  logic [31:0] load_pc4,
    input  logic [31:0] load_instr,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            pc4_d   = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!write_en) begin
            pc4_d   = pc4_q;
        end else if (load) begin
            pc4_d   = load_pc4;
            instr_d = load_instr;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign if_id_pc4   = pc4_q;
    assign if_id_instr = instr_q;
    assign if_id_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, hold buffer, IF/ID register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc4_q, hold_pc4_d;

    logic         redirect;
    logic         grant;
    logic         deliver;
    logic         from_hold;
    logic [31:0]  load_pc4;
    logic [31:0]  load_instr;

    always_comb begin
        redirect     = Exception | Branch_Taken;
        state_d      = state_q;
        imem_req     = 1'b0;
        deliver      = 1'b0;
        from_hold    = 1'b0;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;

        unique case (state_q)
            REQ: imem_req = PCWrite & ~redirect;
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    if (!redirect) begin
                        if (IF_ID_Write) begin
                            deliver  = 1'b1;
                            imem_req = PCWrite;
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc4_d   = req_pc_q + 32'd4;
                            state_d      = HOLD;
                        end
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = REQ;
                end else if (IF_ID_Write) begin
                    deliver   = 1'b1;
                    from_hold = 1'b1;
                    state_d   = REQ;
                end
            end
            DROP: if (imem_rvalid) state_d = REQ;
            default: state_d = REQ;
        endcase

        // A grant is only possible from REQ or a back-to-back delivery in WAIT.
        grant = imem_req & imem_gnt;
        if (grant) state_d = WAIT;

        req_pc_d = grant ? pc_q : req_pc_q;
        if (Exception)         pc_d = EXC_VECTOR;
        else if (Branch_Taken) pc_d = Branch_Target;
        else if (grant)        pc_d = pc_q + 32'd4;
        else                   pc_d = pc_q;

        load_instr = from_hold ? hold_instr_q : imem_rdata;
        load_pc4   = from_hold ? hold_pc4_q : req_pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            hold_instr_q <= NOP_INSTR;
            hold_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    assign imem_addr = pc_q;

    if_id_register u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect),
        .write_en    (IF_ID_Write),
        .load        (deliver),
        .load_pc4    (load_pc4),
        .load_instr  (load_instr),
        .if_id_pc4   (IF_ID_PC4),
        .if_id_instr (IF_ID_Instr),
        .if_id_valid (IF_ID_Valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural imem and an IF/ID scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCWrite, IF_ID_Write, Branch_Taken, Exception;
    logic [31:0] Branch_Target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_ID_PC4, IF_ID_Instr;
    logic        IF_ID_Valid;

    fetch_stage #(.RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h8000_0180)) dut (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target), .Exception(Exception),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_ID_PC4(IF_ID_PC4), .IF_ID_Instr(IF_ID_Instr), .IF_ID_Valid(IF_ID_Valid)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // stimulus knobs and memory model state
    logic        pcw, ifw, br, exc, gnt_en;
    logic [31:0] brt;
    int unsigned lat;
    logic        pend;
    int unsigned cnt;
    logic [31:0] pend_addr;
    logic        obs_req;
    logic [31:0] obs_addr;
    logic [63:0] sb[$];
    logic [63:0] exp_e;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    task automatic tick();
        logic granted, redir;
        @(negedge clk);
        PCWrite       = pcw;
        IF_ID_Write   = ifw;
        Branch_Taken  = br;
        Branch_Target = brt;
        Exception     = exc;
        imem_rvalid   = pend && (cnt == 0);
        imem_rdata    = imem_rvalid ? (32'h2000_0000 | pend_addr) : 32'hDEAD_BEEF;
        imem_gnt      = gnt_en;
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        granted  = imem_req && gnt_en;
        redir    = br | exc;
        if (imem_rvalid) pend = 1'b0;
        else if (pend) cnt--;
        if (granted) begin
            pend      = 1'b1;
            cnt       = lat - 1;
            pend_addr = obs_addr;
            sb.push_back({obs_addr + 32'd4, 32'h2000_0000 | obs_addr});
        end
        @(posedge clk);
        #1;
        if (redir) begin
            chk("flush_valid", {31'b0, IF_ID_Valid}, 32'd0);
            chk("flush_instr", IF_ID_Instr, 32'd0);
            chk("flush_pc4", IF_ID_PC4, 32'd0);
            sb.delete();
        end else if (ifw && IF_ID_Valid) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected observed=%h expected=none", IF_ID_PC4);
            end
            if (sb.size() != 0) begin
                exp_e = sb.pop_front();
                chk("sb_pc4", IF_ID_PC4, exp_e[63:32]);
                chk("sb_instr", IF_ID_Instr, exp_e[31:0]);
            end
        end
        if (!IF_ID_Valid) chk("nop_when_invalid", IF_ID_Instr, 32'd0);
    endtask

    task automatic set_in(logic p, logic w, logic g);
        pcw = p; ifw = w; gnt_en = g; br = 1'b0; exc = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        pend  = 1'b0;
        sb.delete();
        #1;
        chk("rst_valid", {31'b0, IF_ID_Valid}, 32'd0);
        chk("rst_instr", IF_ID_Instr, 32'd0);
        chk("rst_pc4", IF_ID_PC4, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; PCWrite = 1'b0; IF_ID_Write = 1'b1; Branch_Taken = 1'b0;
        Exception = 1'b0; Branch_Target = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; brt = '0; lat = 1; pend = 1'b0; cnt = 0;
        set_in(1'b1, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        reset_dut();

        // zero-wait streaming
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stream_req", {31'b0, obs_req}, 32'd1);
            chk("stream_addr", obs_addr, 32'(4 * i));
            if (i == 0) chk("first_edge_valid", {31'b0, IF_ID_Valid}, 32'd0);
            if (i == 1) chk("second_edge_valid", {31'b0, IF_ID_Valid}, 32'd1);
        end
        set_in(1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk("stream_drained", sb.size(), 32'd0);

        // IF_ID_Write stall while the 0x10 response arrives
        reset_dut();
        set_in(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("hold_pre_addr", obs_addr, 32'h10);
        set_in(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req", {31'b0, obs_req}, 32'd0);
            chk("hold_keep_pc4", IF_ID_PC4, 32'h10);
        end
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        chk("hold_release_pc4", IF_ID_PC4, 32'h14);
        chk("hold_release_instr", IF_ID_Instr, 32'h2000_0010);
        lat = 3;
        tick();
        chk("hold_resume_addr", obs_addr, 32'h14);
        chk("hold_once", {31'b0, IF_ID_Valid}, 32'd0);

        // branch while waiting on a late response
        br = 1'b1; brt = 32'h400;
        tick();
        chk("br_req", {31'b0, obs_req}, 32'd0);
        br = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("drop_req", {31'b0, obs_req}, 32'd0);
            chk("drop_valid", {31'b0, IF_ID_Valid}, 32'd0);
        end
        lat = 1;
        tick();
        chk("br_target_addr", obs_addr, 32'h400);
        chk("br_target_req", {31'b0, obs_req}, 32'd1);
        set_in(1'b0, 1'b1, 1'b1);
        tick();
        chk("br_deliver_pc4", IF_ID_PC4, 32'h404);
        tick();
        chk("br_drained", sb.size(), 32'd0);

        // exception and branch together over an IF/ID stall
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b1);
        exc = 1'b1; br = 1'b1; brt = 32'h400;
        tick();

        // load-use stall in REQ
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        chk("exc_addr", obs_addr, 32'h8000_0180);
        set_in(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_req", {31'b0, obs_req}, 32'd0);
            chk("stall_addr", obs_addr, 32'h8000_0180);
        end
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        chk("stall_resume_addr", obs_addr, 32'h8000_0180);
        tick();
        chk("stall_next_addr", obs_addr, 32'h8000_0184);

        // PC wrap at the top of the address space
        br = 1'b1; brt = 32'hFFFF_FFFC;
        tick();
        br = 1'b0;
        tick();
        chk("wrap_top_addr", obs_addr, 32'hFFFF_FFFC);
        lat = 3;
        tick();
        chk("wrap_addr", obs_addr, 32'h0);
        chk("wrap_req", {31'b0, obs_req}, 32'd1);

        // asynchronous reset while waiting; the late response must be ignored
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, IF_ID_Valid}, 32'd0);
        chk("midrst_pc4", IF_ID_PC4, 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        set_in(1'b0, 1'b1, 1'b1);
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("late_rvalid_valid", {31'b0, IF_ID_Valid}, 32'd0);
        end
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        chk("restart_addr", obs_addr, 32'h0);
        set_in(1'b0, 1'b1, 1'b1);
        tick();
        chk("restart_pc4", IF_ID_PC4, 32'h4);
        tick();
        chk("final_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core; it sits directly upstream of the ID-stage controller. It owns the PC and talks to instruction memory over a single-outstanding request/grant/response interface. It honours the hazard unit's `PCWrite`/`IF_ID_Write` stalls and redirects on taken branches and exceptions. It delivers `{PC+4, instruction, valid}` to ID, inserting bubbles whenever no instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded at reset
- `EXC_VECTOR`, 32'h8000_0180, redirect target on `Exception`
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `PCWrite`  in  1  0 = hazard stall; no new imem request
- `IF_ID_Write`  in  1  0 = hold IF/ID register
- `Branch_Taken`  in  1  taken branch resolved in ID; redirect and squash IF/ID
- `Branch_Target`  in  32  branch destination
- `Exception`  in  1  overflow exception from controller; redirect to `EXC_VECTOR` and squash IF/ID
- `imem_req`  out  1  request valid
- `imem_addr`  out  32  word address, equal to PC
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid, at least 1 cycle after grant
- `imem_rdata`  in  32  instruction
- `IF_ID_PC4`  out  32  fetched PC + 4
- `IF_ID_Instr`  out  32  instruction; 0 (NOP) when invalid
- `IF_ID_Valid`  out  1  IF/ID holds a real instruction

## Operation
- Registers:
  - `pc`: next address to request.
  - `req_pc`: address of the in-flight request.
  - `state`: FSM state.
  - Hold buffer: `hold_instr`, `hold_pc4`.
  - IF/ID triple.
- `redirect = Exception | Branch_Taken`. Target priority is Exception > Branch > sequential. A redirect loads `pc` regardless of `PCWrite`.
- `imem_req` is 0 in any cycle with `redirect` or `PCWrite=0`. Memory samples `imem_addr` only when `imem_req & imem_gnt`. `imem_req` may drop without a grant.
- On `imem_req & imem_gnt`: `req_pc←pc`, `pc←pc+4` (mod 2^32, wraps silently).
- FSM:
  - **REQ**: `imem_req=PCWrite&~redirect`. On grant, go to WAIT. Any `imem_rvalid` seen in REQ is ignored.
  - **WAIT**: awaiting response.
    - `redirect` with no `imem_rvalid` → DROP.
    - `redirect` with `imem_rvalid` → response discarded, go to REQ.
    - `imem_rvalid` & `IF_ID_Write` → deliver. `imem_req` may assert in the same cycle (back-to-back); with grant stay in WAIT, otherwise go to REQ.
    - `imem_rvalid` & `~IF_ID_Write` → capture into hold buffer, go to HOLD.
  - **HOLD**: buffer full, no request issued.
    - `redirect` → buffer discarded, go to REQ.
    - `IF_ID_Write=1` → deliver buffer, go to REQ.
  - **DROP**: `imem_req=0`. On `imem_rvalid`, discard and go to REQ. A further redirect in DROP only updates `pc`.
- IF/ID update priority per edge:
  1. `redirect` → `Valid=0`, `Instr=0`, `PC4=0`. This overrides `IF_ID_Write=0`.
  2. `IF_ID_Write=0` → hold.
  3. Instruction delivered → load, `Valid=1`. `PC4` is `req_pc+4` (or `hold_pc4` when delivering from the hold buffer).
  4. Otherwise → bubble (`Valid=0`, `Instr=0`).

## Timing
- Reset values (async on `rst_n` low):
  - `pc=RESET_PC`, `state=REQ`, hold buffer empty.
  - `IF_ID_PC4=0`, `IF_ID_Instr=0`, `IF_ID_Valid=0`.
  - `imem_req` is 1 combinationally in the first cycle after release if `PCWrite=1`.
- Latency: grant in cycle N, rvalid in N+1 → IF/ID valid after the edge ending N+1. Zero-wait memory sustains 1 instruction/cycle.
- Redirect in cycle N → `imem_addr` = target in N+1 (state REQ), or after the stale response is drained (DROP).
- Reset mid-transaction: any in-flight response is ignored, since the FSM is in REQ.
- `redirect` and `imem_gnt` in the same cycle is impossible because `imem_req=0`.
- `imem_rvalid` with no outstanding request is ignored in every state except WAIT/DROP.

## Structure
- `mips_pkg`: `fetch_state_t` enum {REQ, WAIT, HOLD, DROP}, `NOP_INSTR=32'h0`, default `RESET_PC`/`EXC_VECTOR` constants.
- One sub-module: `if_id_register` (flush/hold/load/bubble priority logic plus the three output registers). The FSM, PC and hold buffer stay in `fetch_stage`.

## Test plan
- Reset release with zero-wait memory returning `0x2000_0000|addr` → `imem_addr` 0,4,8,… on consecutive cycles; `IF_ID_PC4` 4,8,C,… with `Valid=1` from the 2nd edge onward.
- `IF_ID_Write=0` for 3 cycles while the response for 0x10 arrives → HOLD entered, `imem_req=0`. On release, IF/ID gets the instruction at 0x10 with `PC4=0x14` exactly once.
- `Branch_Taken=1`, `Branch_Target=0x400` while in WAIT with the response 2 cycles late → stale response dropped; next `imem_addr=0x400`; IF/ID shows `Valid=0` for the redirect edge.
- `Exception` and `Branch_Taken` asserted together with `IF_ID_Write=0` → `pc=0x8000_0180`, IF/ID flushed to `Valid=0`/`Instr=0`.
- `PCWrite=0` (load-use stall) in REQ → `imem_req=0`, `pc` unchanged. Deassertion resumes at the same address.
- `pc=0xFFFF_FFFC` granted → next `imem_addr=0x0000_0000`; `rst_n` pulsed low while in WAIT → outputs 0, late rvalid ignored, fetch restarts at `RESET_PC`.
